// File: rtl/fpa_pkg.sv
// Shared definitions for the parametrised floating-point add/subtract pipeline:
// rounding-mode codes, flag bit positions, width helpers and stage payload types.
package fpa_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  // Flags = {invalid, overflow, underflow, inexact, zero}
  localparam int FLG_INV  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_NX   = 1;
  localparam int FLG_ZERO = 0;

  localparam int GRD_W = 3;

  function automatic int fpa_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  function automatic int fpa_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fpa_max_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int fpa_guard_w();
    return GRD_W;
  endfunction

  typedef struct packed {
    logic nan;
    logic invalid;
    logic inf;
    logic inf_sign;
  } fpa_special_t;

  typedef struct packed {
    logic         eff_sub;
    logic [1:0]   rm;
    fpa_special_t sp;
  } fpa_ctrl_t;

endpackage

// File: rtl/fpa_norm_round.sv
// Combinational normalise/round stage: leading-zero count with gradual-underflow
// limit, G/R/S rounding per mode, overflow saturation and the special-case mux.
module fpa_norm_round
  import fpa_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int W = fpa_width(EXP_W, FRAC_W),
  localparam int SW = FRAC_W + 2 + GRD_W
) (
  input  logic             sign,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [SW-1:0]    sum,
  input  fpa_ctrl_t        ctrl,
  output logic [W-1:0]     result,
  output logic [4:0]       flags
);

  localparam int MW = SW - 1;
  localparam int LZ_W = $clog2(SW) + 1;
  localparam int CW = (EXP_W + 1 > LZ_W) ? EXP_W + 1 : LZ_W;
  localparam int MAXE = fpa_max_exp(EXP_W);

  logic [CW-1:0] lz;
  logic          found;
  logic [CW-1:0] lim;
  logic [CW-1:0] sh;

  always_comb begin
    lz = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else lz = lz + CW'(1);
      end
    end
  end

  // exp_in is always >= 1, so the shift never takes the exponent below 1
  assign lim = CW'(exp_in) - CW'(1);
  assign sh  = (lz < lim) ? lz : lim;

  logic [MW-1:0]     m;
  logic [EXP_W:0]    ex;
  logic [EXP_W:0]    ex_r;
  logic              up;
  logic              nx;
  logic [FRAC_W+1:0] mr;
  logic [FRAC_W-1:0] frac;
  logic              hidden;
  logic              ovf;
  logic              ovf_inf;
  logic              z_sign;

  always_comb begin
    m = '0;
    ex = '0;
    ex_r = '0;
    up = 1'b0;
    nx = 1'b0;
    mr = '0;
    frac = '0;
    hidden = 1'b0;
    ovf = 1'b0;
    ovf_inf = 1'b0;
    z_sign = sign;
    result = '0;
    flags = '0;

    if (sum[MW]) begin
      m  = {sum[MW:2], sum[1] | sum[0]};
      ex = (EXP_W+1)'(exp_in) + (EXP_W+1)'(1);
    end else begin
      m  = sum[MW-1:0] << sh;
      ex = (EXP_W+1)'(CW'(exp_in) - sh);
    end

    nx = |m[GRD_W-1:0];
    case (ctrl.rm)
      RM_RNE:  up = m[2] & (m[1] | m[0] | m[3]);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign & nx;
      default: up = ~sign & nx;
    endcase

    mr = {1'b0, m[MW-1:GRD_W]} + (FRAC_W+2)'(up);
    if (mr[FRAC_W+1]) begin
      ex_r   = ex + (EXP_W+1)'(1);
      frac   = mr[FRAC_W:1];
      hidden = 1'b1;
    end else begin
      ex_r   = ex;
      frac   = mr[FRAC_W-1:0];
      hidden = mr[FRAC_W];
    end

    ovf = hidden & (ex_r >= (EXP_W+1)'(MAXE));
    ovf_inf = (ctrl.rm == RM_RNE) | ((ctrl.rm == RM_RUP) & ~sign) |
              ((ctrl.rm == RM_RDN) & sign);
    // An exact cancellation has no sign of its own; it follows the rounding mode
    if ((sum == '0) && ctrl.eff_sub) z_sign = (ctrl.rm == RM_RDN);

    result = {z_sign, (hidden ? ex_r[EXP_W-1:0] : {EXP_W{1'b0}}), frac};
    flags[FLG_NX]   = nx;
    flags[FLG_UNF]  = ~hidden & nx;
    flags[FLG_ZERO] = ~hidden & (frac == '0);

    if (ovf) begin
      result = ovf_inf ? {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                       : {sign, EXP_W'(MAXE - 1), {FRAC_W{1'b1}}};
      flags = '0;
      flags[FLG_OVF] = 1'b1;
      flags[FLG_NX]  = 1'b1;
    end
    if (ctrl.sp.inf) begin
      result = {ctrl.sp.inf_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags = '0;
    end
    if (ctrl.sp.nan) begin
      result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      flags = '0;
      flags[FLG_INV] = ctrl.sp.invalid;
    end
  end

endmodule

// File: rtl/fpa_pipeline_hs.sv
// Three-stage IEEE-754 add/subtract pipeline (align -> add -> normalise/round)
// with valid/ready backpressure, a sideband tag and a synchronous flush.
module fpa_pipeline_hs
  import fpa_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W = 4,
  localparam int W = fpa_width(EXP_W, FRAC_W)
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [W-1:0]     OpA,
  input  logic [W-1:0]     OpB,
  input  logic             Sub_Signal,
  input  logic [1:0]       Rm,
  input  logic [TAG_W-1:0] In_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [W-1:0]     Result,
  output logic [TAG_W-1:0] Out_Tag,
  output logic [4:0]       Flags
);

  localparam int MW = FRAC_W + 1 + GRD_W;
  localparam int SW = MW + 1;

  // Handshake: a stage moves forward on a clock edge when its valid is set and the
  // stage after it is ready (empty, or moving on in the same edge); otherwise it
  // holds. Flush empties every stage and blocks acceptance in that cycle.
  logic rdy1, rdy2, rdy3, v1, v2, accept;

  assign rdy3     = !Out_Valid || Out_Ready;
  assign rdy2     = !v2 || rdy3;
  assign rdy1     = !v1 || rdy2;
  assign In_Ready = rdy1;
  assign accept   = In_Valid && rdy1 && !Flush;

  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e, a_ee, b_ee, l_e, s_e, diff;
  logic [FRAC_W-1:0] a_f, b_f;
  logic [FRAC_W:0]  a_m, b_m, l_m, s_m;
  logic             a_big, l_s;
  logic [MW-1:0]    s_ext, s_shift, lost, s_al;
  logic             a_nan, b_nan, a_inf, b_inf, inf_inf;
  fpa_ctrl_t        ctrl_in;

  assign a_s  = OpA[W-1];
  assign b_s  = OpB[W-1] ^ Sub_Signal;
  assign a_e  = OpA[W-2:FRAC_W];
  assign b_e  = OpB[W-2:FRAC_W];
  assign a_f  = OpA[FRAC_W-1:0];
  assign b_f  = OpB[FRAC_W-1:0];
  assign a_ee = (a_e == '0) ? EXP_W'(1) : a_e;
  assign b_ee = (b_e == '0) ? EXP_W'(1) : b_e;
  assign a_m  = {|a_e, a_f};
  assign b_m  = {|b_e, b_f};

  // Exponent-then-fraction field order makes the raw compare a magnitude compare
  assign a_big = OpA[W-2:0] >= OpB[W-2:0];
  assign l_s   = a_big ? a_s : b_s;
  assign l_e   = a_big ? a_ee : b_ee;
  assign s_e   = a_big ? b_ee : a_ee;
  assign l_m   = a_big ? a_m : b_m;
  assign s_m   = a_big ? b_m : a_m;
  assign diff  = l_e - s_e;

  assign s_ext   = {s_m, {GRD_W{1'b0}}};
  assign s_shift = s_ext >> diff;
  assign lost    = s_ext & ~({MW{1'b1}} << diff);
  assign s_al    = {s_shift[MW-1:1], s_shift[0] | (|lost)};

  assign a_nan   = (&a_e) && (a_f != '0);
  assign b_nan   = (&b_e) && (b_f != '0);
  assign a_inf   = (&a_e) && (a_f == '0);
  assign b_inf   = (&b_e) && (b_f == '0);
  assign inf_inf = a_inf && b_inf && ctrl_in.eff_sub;

  assign ctrl_in.eff_sub     = Sub_Signal ^ OpA[W-1] ^ OpB[W-1];
  assign ctrl_in.rm          = Rm;
  assign ctrl_in.sp.nan      = a_nan || b_nan || inf_inf;
  assign ctrl_in.sp.invalid  = (a_nan && !a_f[FRAC_W-1]) || (b_nan && !b_f[FRAC_W-1]) || inf_inf;
  assign ctrl_in.sp.inf      = (a_inf || b_inf) && !ctrl_in.sp.nan;
  assign ctrl_in.sp.inf_sign = a_inf ? a_s : b_s;

  logic             s1_sign, s2_sign;
  logic [EXP_W-1:0] s1_exp, s2_exp;
  logic [MW-1:0]    s1_ml, s1_ms;
  logic [SW-1:0]    s2_sum, sum;
  fpa_ctrl_t        s1_ctrl, s2_ctrl;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [W-1:0]     nr_result;
  logic [4:0]       nr_flags;

  // The larger magnitude is always the minuend, so the difference never goes negative
  assign sum = s1_ctrl.eff_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms})
                               : ({1'b0, s1_ml} + {1'b0, s1_ms});

  fpa_norm_round #(
    .EXP_W (EXP_W),
    .FRAC_W(FRAC_W)
  ) u_norm_round (
    .sign  (s2_sign),
    .exp_in(s2_exp),
    .sum   (s2_sum),
    .ctrl  (s2_ctrl),
    .result(nr_result),
    .flags (nr_flags)
  );

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      Out_Valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp <= '0;
      s1_ml <= '0;
      s1_ms <= '0;
      s1_ctrl <= '0;
      s1_tag <= '0;
      s2_sign <= 1'b0;
      s2_exp <= '0;
      s2_sum <= '0;
      s2_ctrl <= '0;
      s2_tag <= '0;
      Result <= '0;
      Out_Tag <= '0;
      Flags <= '0;
    end else begin
      if (Flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        Out_Valid <= 1'b0;
      end else begin
        if (rdy1) v1 <= In_Valid;
        if (rdy2) v2 <= v1;
        if (rdy3) Out_Valid <= v2;
      end
      if (accept) begin
        s1_sign <= l_s;
        s1_exp <= l_e;
        s1_ml <= {l_m, {GRD_W{1'b0}}};
        s1_ms <= s_al;
        s1_ctrl <= ctrl_in;
        s1_tag <= In_Tag;
      end
      if (v1 && rdy2 && !Flush) begin
        s2_sign <= s1_sign;
        s2_exp <= s1_exp;
        s2_sum <= sum;
        s2_ctrl <= s1_ctrl;
        s2_tag <= s1_tag;
      end
      if (v2 && rdy3 && !Flush) begin
        Result <= nr_result;
        Out_Tag <= s2_tag;
        Flags <= nr_flags;
      end
    end
  end

endmodule

// File: doc/fpa_pipeline_hs.md
Name: fpa_pipeline_hs

Overview:
- Parametrised IEEE-754 floating-point add/subtract pipeline.
- Successor to the fixed binary32 three-stage adder: exponent and fraction widths are generic.
- Replaces the per-register enables with valid/ready backpressure, a sideband tag, sticky-free per-result exception flags and a synchronous flush.
- Sits between the FPU issue logic and the writeback arbiter; sustains one operation per cycle.

Parameters:
EXP_W, 8, exponent field width (>=4)
FRAC_W, 23, stored fraction width (>=4); operand width W = 1+EXP_W+FRAC_W
TAG_W, 4, sideband tag width carried unchanged with each operation

Ports:
Clk  in  1  clock, rising edge
Clear  in  1  asynchronous active-low reset
Flush  in  1  synchronous; drops all in-flight operations
In_Valid  in  1  operation present
In_Ready  out  1  block accepts the operation this cycle
OpA  in  W  operand A
OpB  in  W  operand B
Sub_Signal  in  1  1 = A-B, 0 = A+B
Rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
In_Tag  in  TAG_W  sideband tag
Out_Valid  out  1  result present
Out_Ready  in  1  consumer takes the result
Result  out  W  rounded sum
Out_Tag  out  TAG_W  tag of this result
Flags  out  5  {invalid, overflow, underflow, inexact, zero}

Behaviour:
- Clock and reset: one clock Clk. Clear is an asynchronous, active-low reset.
- Reset values: Out_Valid=0, Result=0, Out_Tag=0, Flags=0, all stage valids=0, In_Ready=1 once Clear deasserts.
- Pipeline: three register stages. S1 holds aligned operands (align logic is combinational from the inputs); S2 holds the added fraction; S3 is the output register (normalise and round logic is combinational from S2).
- Latency: an operation accepted at edge E0 is presented on the outputs after edge E0+2.
- Handshake: stage k advances when its valid is set and it is ready: rdy3 = !Out_Valid | Out_Ready, rdy2 = !v2 | rdy3, rdy1 = !v1 | rdy2, In_Ready = rdy1.
  - A stage that cannot advance holds its data unchanged.
  - Result, Out_Tag and Flags stay stable while Out_Valid=1 and Out_Ready=0.
- Ordering and throughput: results leave in acceptance order. Throughput is 1 op/cycle with Out_Ready held high. With Out_Ready held low the pipe holds 3 operations, then In_Ready=0.
- Flush: clears v1, v2 and Out_Valid at the next edge. An In_Valid in the same cycle is not accepted. Flush overrides In_Valid and Out_Ready.
- Align: the operand with the larger magnitude is "large". The small fraction gets the hidden bit, then 3 guard/round/sticky bits, then is right-shifted by the exponent difference; bits shifted out OR into sticky. Subnormals use hidden bit 0 and effective exponent 1.
- Calculate: effective subtraction = Sub_Signal XOR signA XOR signB. Sum width is FRAC_W+5.
- Normalise: carry-out shifts right 1 and increments the exponent. Otherwise leading-zero shift left, limited so the exponent does not drop below 1 (gradual underflow).
- Round: per Rm, using G/R/S. Rounding carry renormalises.
- Special cases:
  - Any NaN input, or inf-inf effective subtraction: canonical qNaN (sign 0, exp all 1, frac MSB 1, rest 0). invalid=1 only for inf-inf or a signalling NaN input.
  - Inf with a finite operand: inf with the inf operand's effective sign, no flags.
  - Exact-zero sum of opposite operands: +0, except RDN gives -0. zero=1.
- Overflow: RNE gives inf. RTZ gives max finite. RUP gives +inf for positive results, max finite for negative. RDN gives -inf for negative results, max finite for positive. overflow and inexact are set.
- underflow: set when the result is subnormal (or zero after rounding) and inexact.
- Reset mid-operation: all in-flight operations are lost, no output is produced.

Decomposition:
- Package fpa_pkg:
  - Rm encodings RM_RNE/RM_RTZ/RM_RDN/RM_RUP.
  - Flag bit indices FLG_INV..FLG_ZERO.
  - Width functions of EXP_W/FRAC_W: W, bias, max-exp, guard width.
  - Stage-payload struct typedefs.
- One sub-module, fpa_norm_round: combinational leading-zero count, shift, round and special-case mux, parametrised the same way.

Test Plan:
- RNE: OpA=0x3F800000, OpB=0x40000000, Sub=0 -> Result=0x40400000, Flags=0, after edge E0+2.
- Exact cancellation: OpA=OpB=0x3F800000, Sub=1, Rm=RNE -> 0x00000000, zero=1. Same operation with Rm=RDN -> 0x80000000.
- inf-inf: OpA=0x7F800000, OpB=0x7F800000, Sub=1 -> 0x7FC00000, invalid=1. OpA=0x7F800000 + OpB=0x3F800000 -> 0x7F800000, Flags=0.
- Overflow: 0x7F7FFFFF+0x7F7FFFFF, RNE -> 0x7F800000, overflow=1, inexact=1. Same with RTZ -> 0x7F7FFFFF.
- Backpressure: issue 5 back-to-back ops with Out_Ready=0 -> In_Ready drops after 3 accepted. Raise Out_Ready -> all 5 results emerge in order with correct tags; outputs stable while stalled.
- Flush and reset: Flush with 2 ops in flight and In_Valid=1 -> no outputs, the new op is not accepted. Clear low mid-stream -> Out_Valid=0 immediately (asynchronous), all state reset.
